// File: rtl/sr_drive_sequencer.sv
// sr_drive_sequencer: turns a stream of requested flip-flop values into
// timed set/reset pulses for an external SR flip-flop. It remembers the
// value it last wrote so redundant requests can be dropped.
// Optional feature macro: SR_FEEDBACK_CHECK_EN adds a CHECK state that
// compares q_fb/qn_fb against the remembered value and raises a sticky err.
module sr_drive_sequencer #(
    parameter int PULSE_CYCLES   = 2,
    parameter int SKIP_REDUNDANT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic din_valid,
    output logic din_ready,
    output logic s,
    output logic r,
    input  logic q_fb,
    input  logic qn_fb,
    output logic busy,
    output logic err
);

`ifdef SR_FEEDBACK_CHECK_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        CHECK = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;
`endif

    // Counter starts one below the pulse length so that reaching zero marks the last pulse cycle.
    localparam logic [7:0] LOAD_VALUE = 8'(PULSE_CYCLES - 1);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_s;
    logic       r_r;
    logic       r_model;
    logic       r_known;
    logic       r_din_cap;

    state_t     w_state_nxt;
    logic [7:0] w_cnt_nxt;
    logic       w_s_nxt;
    logic       w_r_nxt;
    logic       w_model_nxt;
    logic       w_known_nxt;
    logic       w_din_cap_nxt;
    logic       w_transfer;
    logic       w_redundant;

`ifdef SR_FEEDBACK_CHECK_EN
    logic       r_err;
    logic       w_err_nxt;
`else
    logic       w_unused_fb;
`endif

    assign w_transfer  = din_valid && (r_state == IDLE);
    assign w_redundant = (SKIP_REDUNDANT != 0) && r_known && (din == r_model);

    // Next-state and next-output decisions for the command sequencer.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_s_nxt       = r_s;
        w_r_nxt       = r_r;
        w_model_nxt   = r_model;
        w_known_nxt   = r_known;
        w_din_cap_nxt = r_din_cap;
`ifdef SR_FEEDBACK_CHECK_EN
        w_err_nxt     = r_err;
`endif
        case (r_state)
            IDLE: begin
                w_s_nxt = 1'b0;
                w_r_nxt = 1'b0;
                if (w_transfer && !w_redundant) begin
                    w_state_nxt   = PULSE;
                    w_s_nxt       = din;
                    w_r_nxt       = ~din;
                    w_cnt_nxt     = LOAD_VALUE;
                    w_din_cap_nxt = din;
                end
            end
            PULSE: begin
                if (r_cnt == 8'd0) begin
                    w_state_nxt = GAP;
                    w_s_nxt     = 1'b0;
                    w_r_nxt     = 1'b0;
                    w_model_nxt = r_din_cap;
                    w_known_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            GAP: begin
                w_s_nxt = 1'b0;
                w_r_nxt = 1'b0;
`ifdef SR_FEEDBACK_CHECK_EN
                w_state_nxt = CHECK;
`else
                w_state_nxt = IDLE;
`endif
            end
`ifdef SR_FEEDBACK_CHECK_EN
            CHECK: begin
                w_s_nxt = 1'b0;
                w_r_nxt = 1'b0;
                if ((q_fb != r_model) || (qn_fb == q_fb)) begin
                    w_err_nxt = 1'b1;
                end
                w_state_nxt = IDLE;
            end
`endif
            default: begin
                w_state_nxt = IDLE;
                w_s_nxt     = 1'b0;
                w_r_nxt     = 1'b0;
            end
        endcase
    end

    // State register; reset aborts any command in flight and forgets the remembered value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= 8'd0;
            r_s       <= 1'b0;
            r_r       <= 1'b0;
            r_model   <= 1'b0;
            r_known   <= 1'b0;
            r_din_cap <= 1'b0;
`ifdef SR_FEEDBACK_CHECK_EN
            r_err     <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_s       <= w_s_nxt;
            r_r       <= w_r_nxt;
            r_model   <= w_model_nxt;
            r_known   <= w_known_nxt;
            r_din_cap <= w_din_cap_nxt;
`ifdef SR_FEEDBACK_CHECK_EN
            r_err     <= w_err_nxt;
`endif
        end
    end

    assign s         = r_s;
    assign r         = r_r;
    assign busy      = (r_state != IDLE);
    assign din_ready = (r_state == IDLE);

`ifdef SR_FEEDBACK_CHECK_EN
    assign err = r_err;
`else
    // Feedback is not monitored in this build; the ports exist only for pin compatibility.
    assign w_unused_fb = q_fb ^ qn_fb;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_sr_drive_sequencer.sv
// Testbench for sr_drive_sequencer. Three instances share one stimulus
// stream: (PULSE_CYCLES=2, SKIP=1), (2, SKIP=0) and (4, SKIP=1). Each is
// compared every cycle against a timeline model driven by the time of the
// last issued command. Honours SR_FEEDBACK_CHECK_EN when defined.
module tb_sr_drive_sequencer;

`ifdef SR_FEEDBACK_CHECK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic din;
    logic dinValid;
    logic qFb;
    logic qnFb;

    logic sO[3];
    logic rO[3];
    logic readyO[3];
    logic busyO[3];
    logic errO[3];

    int   total = 0;
    int   bad = 0;
    int   edgeCnt = 0;

    // Model: edge number at which each instance issued its current command (-1 = none).
    int   issT[3];
    logic issV[3];
    logic mKnown[3];
    logic mModel[3];
    logic mErr[3];

    always #5 clk = ~clk;

    sr_drive_sequencer #(.PULSE_CYCLES(2), .SKIP_REDUNDANT(1)) dut0 (
        .clk(clk), .rst(rst), .din(din), .din_valid(dinValid), .din_ready(readyO[0]),
        .s(sO[0]), .r(rO[0]), .q_fb(qFb), .qn_fb(qnFb), .busy(busyO[0]), .err(errO[0]));

    sr_drive_sequencer #(.PULSE_CYCLES(2), .SKIP_REDUNDANT(0)) dut1 (
        .clk(clk), .rst(rst), .din(din), .din_valid(dinValid), .din_ready(readyO[1]),
        .s(sO[1]), .r(rO[1]), .q_fb(qFb), .qn_fb(qnFb), .busy(busyO[1]), .err(errO[1]));

    sr_drive_sequencer #(.PULSE_CYCLES(4), .SKIP_REDUNDANT(1)) dut2 (
        .clk(clk), .rst(rst), .din(din), .din_valid(dinValid), .din_ready(readyO[2]),
        .s(sO[2]), .r(rO[2]), .q_fb(qFb), .qn_fb(qnFb), .busy(busyO[2]), .err(errO[2]));

    function automatic int pcOf(input int i);
        return (i == 2) ? 4 : 2;
    endfunction

    function automatic bit skipOf(input int i);
        return (i != 1);
    endfunction

    // Position of the current cycle within the command: 1..PC pulse, PC+1 gap, PC+2 check.
    function automatic int phaseOf(input int i);
        return edgeCnt - issT[i] + 1;
    endfunction

    function automatic bit expActive(input int i);
        if (issT[i] < 0) return 1'b0;
        return (phaseOf(i) >= 1) && (phaseOf(i) <= pcOf(i) + 1 + CHK);
    endfunction

    function automatic logic expS(input int i);
        return expActive(i) && (phaseOf(i) <= pcOf(i)) && issV[i];
    endfunction

    function automatic logic expR(input int i);
        return expActive(i) && (phaseOf(i) <= pcOf(i)) && !issV[i];
    endfunction

    task automatic checkOne(input string tag, input int i, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s inst%0d cycle=%0d observed=%b expected=%b", tag, i, edgeCnt, obs, exp);
        end
    endtask

    task automatic checkOutput();
        for (int i = 0; i < 3; i++) begin
            checkOne("s", i, sO[i], expS(i));
            checkOne("r", i, rO[i], expR(i));
            checkOne("busy", i, busyO[i], expActive(i));
            checkOne("din_ready", i, readyO[i], !expActive(i));
            checkOne("err", i, errO[i], mErr[i]);
            checkOne("s_and_r", i, sO[i] & rO[i], 1'b0);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 3; i++) begin
            issT[i]   = -1;
            issV[i]   = 1'b0;
            mKnown[i] = 1'b0;
            mModel[i] = 1'b0;
            mErr[i]   = 1'b0;
        end
    endtask

    // Advance the model across one rising edge using the inputs present at that edge.
    task automatic modelStep();
        for (int i = 0; i < 3; i++) begin
            int k;
            k = phaseOf(i);
            if (rst) begin
                issT[i]   = -1;
                mKnown[i] = 1'b0;
                mModel[i] = 1'b0;
                mErr[i]   = 1'b0;
            end else if (expActive(i)) begin
                if (k == pcOf(i)) begin
                    mModel[i] = issV[i];
                    mKnown[i] = 1'b1;
                end
                if ((CHK != 0) && (k == pcOf(i) + 2)) begin
                    if ((qFb != mModel[i]) || (qnFb == qFb)) mErr[i] = 1'b1;
                end
            end else if (dinValid) begin
                if (!(skipOf(i) && mKnown[i] && (din == mModel[i]))) begin
                    issT[i] = edgeCnt + 1;
                    issV[i] = din;
                end
            end
        end
        edgeCnt++;
    endtask

    // One clock cycle: check outputs mid-cycle, present new inputs, then step the model at the edge.
    task automatic applyStimulus(input logic iRst, input logic iValid, input logic iDin,
                                 input logic iQ, input logic iQn);
        @(negedge clk);
        checkOutput();
        rst      = iRst;
        dinValid = iValid;
        din      = iDin;
        qFb      = iQ;
        qnFb     = iQn;
        @(posedge clk);
        modelStep();
    endtask

    initial begin
        logic seq[3];
        int   j;
        rst      = 1'b1;
        dinValid = 1'b0;
        din      = 1'b0;
        qFb      = 1'b0;
        qnFb     = 1'b1;
        repeat (3) @(posedge clk);
        modelReset();

        $display("[TB] reset and single din=1 command");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("[TB] redundant din=1 request");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("[TB] alternating 1,0,1 with din_valid held");
        seq[0] = 1'b1;
        seq[1] = 1'b0;
        seq[2] = 1'b1;
        j = 0;
        for (int c = 0; c < 40 && j < 3; c++) begin
            bit acc;
            acc = !expActive(0);
            applyStimulus(1'b0, 1'b1, seq[j], seq[j], ~seq[j]);
            if (acc) j++;
        end
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("[TB] reset on second pulse cycle");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("[TB] bad feedback then good commands");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 400; c++) begin
            logic q;
            q = 1'($urandom_range(0, 1));
            applyStimulus(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), q,
                          ($urandom_range(0, 7) == 0) ? q : ~q);
        end

        @(negedge clk);
        checkOutput();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
